freq_stimulus_gen: RTL and testbench
====================================

// Module: freq_stimulus_gen
// PURPOSE
//  Programmable square-wave source plus measurement-gate generator; the transmit end of the
//  frequency-counter path. Drives a known-frequency wave and a periodic gate into the counter,
//  and reports the number of rising edges it emitted per gate window for self-check.
//  Sits beside the counter on the board top and in the counter's benches as a stimulus source.
// PARAMETERS
//  DIV_W        27           width of half-period divider (cycles of clk)
//  GATE_CYCLES  100_000_000  gate-window length in clk cycles (1 s at 100 MHz); >=2
//  CNT_W        27           width of emitted-edge counter; saturates at all-ones
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  reset        in   1       asynchronous, active-high reset
//  enable       in   1       1 = run generator and gate; 0 = stop (see BEHAVIOUR)
//  div_in       in   DIV_W   requested half-period in clk cycles; 0 is illegal
//  load         in   1       1-cycle request to adopt div_in
//  load_ack     out  1       1-cycle pulse: div_in accepted into pending register
//  load_err     out  1       1-cycle pulse: load with div_in==0, request dropped
//  wave_out     out  1       square wave, period 2*div cycles, 50% duty
//  gate_out     out  1       measurement gate, high GATE_CYCLES, low GATE_CYCLES
//  edge_count   out  CNT_W   rising edges of wave_out during last completed gate-high window
//  count_valid  out  1       1-cycle pulse when edge_count updates
// BEHAVIOUR
//  Reset: wave_out=0, gate_out=0, edge_count=0, count_valid=0, load_ack=0, load_err=0,
//   div register=1, pending empty, state IDLE, all counters 0.
//  FSM states: IDLE, RUN, PEND.
//   IDLE: enable=1 -> RUN next cycle; half-period counter starts at 0.
//   RUN : half counter increments; at count==div-1: wave_out toggles, counter->0.
//   PEND: as RUN, but new div waits; applied at next wave_out toggle (glitch-free), then RUN.
//   Any state, enable=0 -> IDLE next cycle; wave_out, gate_out, all counters cleared;
//    div register and pending value kept; no count_valid emitted for aborted window.
//  Load handling (any state, including IDLE):
//   load=1, div_in!=0: capture to pending, load_ack next cycle; RUN->PEND; in IDLE apply
//    immediately to div register. Second load while PEND overwrites pending, acks again.
//   load=1, div_in==0: load_err next cycle, no state change.
//   load on same cycle as a toggle in PEND: toggle uses old div, new value applied next toggle.
//  Gate: gate counter 0..GATE_CYCLES-1 runs in RUN/PEND; at terminal count gate_out toggles.
//   First gate_out rise GATE_CYCLES cycles after entering RUN.
//   Edge counter clears on gate_out rise; counts cycles where wave_out goes 0->1 and
//    gate_out=1; saturates at 2^CNT_W-1.
//   On gate_out fall: edge_count <= edge counter (including an edge on that same cycle),
//    count_valid=1 for exactly that cycle.
//  Expected edge_count = floor/ceil of GATE_CYCLES/(2*div) depending on phase (±1).
//  Reset mid-operation: all outputs to reset values immediately (async), no pulses.
// TESTING (sim with GATE_CYCLES=100)
//  1 reset, enable=1, load div_in=5 in IDLE -> load_ack 1 cycle; wave_out period 10 clk;
//    first count_valid 200 cycles after RUN, edge_count=10.
//  2 running div=5, load div_in=2 mid half-period -> current half completes at 5 cycles,
//    subsequent half-periods 2 cycles; no runt pulse shorter than 2.
//  3 load div_in=0 -> load_err pulse, load_ack stays 0, period unchanged.
//  4 div=1 -> wave_out toggles every cycle; edge_count=50 each window.
//  5 deassert enable at cycle 150 of window -> wave_out=0, gate_out=0 next cycle,
//    no count_valid; re-enable -> gate restarts, full 100-cycle window.
//  6 assert reset during gate-high window -> all outputs 0 asynchronously; div back to 1.

Source files
------------

// File: rtl/freq_stimulus_gen.sv
// Square-wave source with a periodic measurement gate; reports emitted rising edges per gate-high window.
// Outputs are registered (1-cycle latency from the triggering edge); there is no backpressure, so pulses are never held.
module freq_stimulus_gen #(
  parameter int DIV_W       = 27,
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  input  logic             load,
  output logic             load_ack,
  output logic             load_err,
  output logic             wave_out,
  output logic             gate_out,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid
);

  localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, pend_q, half_cnt;
  logic             pend_vld;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic             running, active, load_ok, load_bad;
  logic             toggle, gate_tc, wave_rise;

  assign running      = (state_q != IDLE);
  assign active       = running && enable;
  assign load_ok      = load && (div_in != '0);
  assign load_bad     = load && (div_in == '0);
  assign toggle       = running && (half_cnt == div_q - DIV_W'(1));
  assign gate_tc      = running && (gate_cnt == GATE_LAST);
  assign wave_rise    = toggle && !wave_out;
  assign edge_cnt_nxt = (wave_rise && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A value left pending by a disable is still applied at the first toggle after restart.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = (pend_vld && !load_ok) ? PEND : RUN;
      RUN:     if (load_ok) state_d = PEND;
      PEND:    if (toggle && !load_ok) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Divider only changes while the half-period counter restarts, so wave_out never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= DIV_W'(1);
      pend_q   <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (load_ok) pend_q <= div_in;
      if (!running) begin
        if (load_ok) begin
          div_q    <= div_in;
          pend_vld <= 1'b0;
        end
      end else begin
        if (toggle && enable && pend_vld) div_q <= pend_q;
        pend_vld <= load_ok || (pend_vld && !(toggle && enable));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt    <= '0;
      gate_cnt    <= '0;
      wave_out    <= 1'b0;
      gate_out    <= 1'b0;
      edge_cnt    <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
      load_ack    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      load_ack    <= load_ok;
      load_err    <= load_bad;
      if (!active) begin
        half_cnt <= '0;
        gate_cnt <= '0;
        wave_out <= 1'b0;
        gate_out <= 1'b0;
        edge_cnt <= '0;
      end else begin
        half_cnt <= toggle ? '0 : half_cnt + DIV_W'(1);
        wave_out <= wave_out ^ toggle;
        gate_cnt <= gate_tc ? '0 : gate_cnt + GW'(1);
        gate_out <= gate_out ^ gate_tc;
        // The closing edge of the window is counted before the result is published.
        if (gate_tc && !gate_out) begin
          edge_cnt <= '0;
        end else if (gate_out) begin
          edge_cnt <= edge_cnt_nxt;
          if (gate_tc) begin
            edge_count  <= edge_cnt_nxt;
            count_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_stimulus_gen.sv
// Bench for freq_stimulus_gen: directed scenarios and random traffic against a time-based model.
module tb_freq_stimulus_gen;
  localparam int DIV_W = 8;
  localparam int GATE  = 100;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             load = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             load_ack, load_err, wave_out, gate_out, count_valid;
  logic [CNT_W-1:0] edge_count;

  freq_stimulus_gen #(.DIV_W(DIV_W), .GATE_CYCLES(GATE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_in(div_in), .load(load),
    .load_ack(load_ack), .load_err(load_err), .wave_out(wave_out), .gate_out(gate_out),
    .edge_count(edge_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_t is the number of running cycles since the generator started, the gate
  // level is simply (m_t / GATE) mod 2, m_half counts down the cycles left in the half period.
  int m_run, m_div, m_pend, m_pvld, m_half, m_t, m_wave, m_edges, m_ecount, m_cv, m_ack, m_err;

  function automatic int m_gate();
    return m_run ? (m_t / GATE) % 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_div = 1; m_pend = 0; m_pvld = 0; m_half = 0; m_t = 0;
    m_wave = 0; m_edges = 0; m_ecount = 0; m_cv = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ack, err, was_run, tog, rise;
    int og, ng;
    ack = load && (div_in != 0);
    err = load && (div_in == 0);
    was_run = m_run;
    m_cv = 0;
    if (!enable) begin
      if (ack) begin
        if (was_run) begin m_pend = div_in; m_pvld = 1; end
        else begin m_div = div_in; m_pvld = 0; end
      end
      m_run = 0; m_t = 0; m_wave = 0; m_edges = 0;
    end else if (!was_run) begin
      if (ack) begin m_div = div_in; m_pvld = 0; end
      m_run = 1; m_t = 0; m_half = m_div; m_wave = 0; m_edges = 0;
    end else begin
      tog  = (m_half == 1);
      rise = tog && !m_wave;
      og = (m_t / GATE) % 2;
      m_t++;
      ng = (m_t / GATE) % 2;
      if (tog) begin
        if (m_pvld) begin m_div = m_pend; m_pvld = 0; end
        m_half = m_div;
      end else begin
        m_half--;
      end
      if (ack) begin m_pend = div_in; m_pvld = 1; end
      if (tog) m_wave = !m_wave;
      if (ng && !og) m_edges = 0;
      else if (og) begin
        if (rise && m_edges < CMAX) m_edges++;
        if (!ng) begin m_ecount = m_edges; m_cv = 1; end
      end
    end
    m_ack = ack;
    m_err = err;
  endtask

  task automatic compare();
    chk("wave_out", wave_out, m_wave);
    chk("gate_out", gate_out, m_gate());
    chk("edge_count", edge_count, m_ecount);
    chk("count_valid", count_valid, m_cv);
    chk("load_ack", load_ack, m_ack);
    chk("load_err", load_err, m_err);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles_to_toggle(output int n);
    logic p;
    p = wave_out;
    n = 0;
    do begin
      cyc();
      load = 1'b0;
      n++;
    end while (wave_out == p && n < 64);
  endtask

  task automatic wait_cv(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!count_valid && n < 400);
    chk("count_valid_seen", count_valid, 1);
  endtask

  task automatic wait_gate_high();
    int n;
    n = 0;
    while (!gate_out && n < 400) begin
      cyc();
      n++;
    end
    chk("gate_rise_seen", gate_out, 1);
  endtask

  initial begin
    int n;
    model_reset();
    #1 reset = 1'b1;
    #20;
    chk("reset_wave", wave_out, 0);
    chk("reset_gate", gate_out, 0);
    chk("reset_edge_count", edge_count, 0);
    chk("reset_cv", count_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    compare();

    // Load 5 while idle and start; first window result after 200 cycles.
    enable = 1'b1; load = 1'b1; div_in = 8'd5;
    cyc();
    load = 1'b0;
    chk("t1_load_ack", load_ack, 1);
    wait_cv(n);
    chk("t1_cv_latency", n, 200);
    chk("t1_edge_count", edge_count, 10);

    // Change to 2 mid half-period: current half finishes on the old divider.
    cycles_to_toggle(n);
    chk("t2_pre_half", n, 5);
    cyc(); cyc();
    load = 1'b1; div_in = 8'd2;
    cycles_to_toggle(n);
    chk("t2_finish_old_half", n, 3);
    cycles_to_toggle(n);
    chk("t2_new_half", n, 2);

    // Zero divider is rejected.
    load = 1'b1; div_in = 8'd0;
    cyc();
    load = 1'b0;
    chk("t3_load_err", load_err, 1);
    chk("t3_load_ack", load_ack, 0);
    cycles_to_toggle(n);
    cycles_to_toggle(n);
    chk("t3_half_unchanged", n, 2);

    // Divider 1: toggle every cycle, 50 edges per window.
    load = 1'b1; div_in = 8'd1;
    cyc();
    load = 1'b0;
    wait_cv(n);
    wait_cv(n);
    chk("t4_edge_count", edge_count, 50);

    // Disable 50 cycles into a gate-high window, then restart.
    wait_gate_high();
    repeat (50) cyc();
    enable = 1'b0;
    cyc();
    chk("t5_wave_off", wave_out, 0);
    chk("t5_gate_off", gate_out, 0);
    repeat (5) cyc();
    enable = 1'b1;
    cyc();
    n = 0;
    do begin cyc(); n++; end while (!gate_out && n < 400);
    chk("t5_gate_restart", n, 100);
    wait_cv(n);
    chk("t5_full_window", edge_count, 50);

    // Divider back to 5, then asynchronous reset inside a gate-high window.
    load = 1'b1; div_in = 8'd5;
    cyc();
    load = 1'b0;
    wait_gate_high();
    repeat (20) cyc();
    #2 reset = 1'b1;
    #1;
    chk("t6_wave", wave_out, 0);
    chk("t6_gate", gate_out, 0);
    chk("t6_edge_count", edge_count, 0);
    chk("t6_cv", count_valid, 0);
    chk("t6_ack", load_ack, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc();
    cyc();
    chk("t6_div1_high", wave_out, 1);
    cyc();
    chk("t6_div1_low", wave_out, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 399) != 0);
      load   = ($urandom_range(0, 39) == 0);
      div_in = DIV_W'($urandom_range(0, 6));
      cyc();
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
